// File: rtl/datapoint_fetch_streamer.sv
// datapoint_fetch_streamer
//   Read-side sequencer for the 1024 x 16 datapoint buffer memory
//   (synchronous read, 1-cycle latency). A start command captures a base
//   address and a word count. The block then reads that contiguous run,
//   wrapping from the top address to 0, and streams the words downstream
//   over a valid/ready handshake. A 2-entry skid FIFO absorbs backpressure,
//   so no word is dropped or read twice.
//
// Ports
//   clock, reset           rising-edge clock, async active-low reset
//   io_start               command pulse, honoured only while idle
//   io_baseAddr, io_len    first address / word count (count clamped to 1024)
//   io_memRdEn, io_memAddr memory read strobe and address
//   io_memRdData           memory data, valid the cycle after io_memRdEn
//   io_outValid/Data/Ready stream handshake; io_outLast marks the final word
//   io_busy                high while fetching or draining
//   io_done                one-cycle pulse when the burst completes
//   io_stallCycles         (only with DATAPOINT_FETCH_PERF_EN) count of
//                          valid && !ready cycles in the current burst,
//                          saturating at 16'hFFFF
//
// Optional feature macro: DATAPOINT_FETCH_PERF_EN
module datapoint_fetch_streamer #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 16,
  parameter int LEN_W  = 11
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              io_start,
  input  logic [ADDR_W-1:0] io_baseAddr,
  input  logic [LEN_W-1:0]  io_len,
  output logic              io_memRdEn,
  output logic [ADDR_W-1:0] io_memAddr,
  input  logic [DATA_W-1:0] io_memRdData,
  output logic              io_outValid,
  output logic [DATA_W-1:0] io_outData,
  input  logic              io_outReady,
  output logic              io_outLast,
  output logic              io_busy,
  output logic              io_done
`ifdef DATAPOINT_FETCH_PERF_EN
  ,
  output logic [15:0]       io_stallCycles
`endif
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(2 ** ADDR_W);

  state_t                       state_q, state_d;
  logic [ADDR_W-1:0]            addr_q, addr_d;
  logic [LEN_W-1:0]             remain_q, remain_d;
  logic [LEN_W-1:0]             len_q, len_d;
  logic [LEN_W-1:0]             out_idx_q, out_idx_d;
  logic [1:0][DATA_W-1:0]       fifo_q, fifo_d;
  logic                         wr_ptr_q, wr_ptr_d;
  logic                         rd_ptr_q, rd_ptr_d;
  logic [1:0]                   count_q, count_d;
  logic                         inflight_q, inflight_d;
  logic                         busy_q, busy_d;
  logic                         done_q, done_d;

  logic                         push_s;
  logic                         pop_s;
  logic                         rd_en_s;
  logic                         start_s;
  logic [2:0]                   occupancy_s;
  logic [LEN_W-1:0]             len_clamped_s;

  // Handshake decode, issue gating and length clamping.
  always_comb begin
    push_s        = inflight_q;
    pop_s         = (count_q != 2'd0) && io_outReady;
    start_s       = (state_q == ST_IDLE) && io_start;
    len_clamped_s = (io_len > MAX_LEN) ? MAX_LEN : io_len;
    // Occupancy counts the pop happening this cycle, so a word leaving the
    // FIFO frees its slot immediately and the stream sustains 1 word/cycle.
    // A read issued now still always finds a free slot when it returns.
    occupancy_s   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop_s};
    rd_en_s       = (state_q == ST_FETCH) && (remain_q != {LEN_W{1'b0}}) &&
                    (occupancy_s < 3'd2);
  end

  // Skid FIFO next-state: push returning memory data, pop on transfer.
  always_comb begin
    fifo_d   = fifo_q;
    count_d  = count_q + {1'b0, push_s} - {1'b0, pop_s};
    if (push_s) begin
      fifo_d[wr_ptr_q] = io_memRdData;
      wr_ptr_d         = ~wr_ptr_q;
    end else begin
      wr_ptr_d         = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
  end

  // Sequencer next-state: command capture, address/length counters, FSM.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    len_d      = len_q;
    out_idx_d  = out_idx_q;
    inflight_d = rd_en_s;

    if (rd_en_s) begin
      // Natural ADDR_W-bit overflow gives the 1023 -> 0 wrap.
      addr_d   = addr_q + ADDR_W'(1);
      remain_d = remain_q - LEN_W'(1);
    end else begin
      addr_d   = addr_q;
      remain_d = remain_q;
    end

    if (pop_s) begin
      out_idx_d = out_idx_q + LEN_W'(1);
    end else begin
      out_idx_d = out_idx_q;
    end

    case (state_q)
      ST_IDLE: begin
        if (io_start) begin
          addr_d    = io_baseAddr;
          remain_d  = len_clamped_s;
          len_d     = len_clamped_s;
          out_idx_d = {LEN_W{1'b0}};
          state_d   = (len_clamped_s == {LEN_W{1'b0}}) ? ST_DONE : ST_FETCH;
        end else begin
          state_d   = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (rd_en_s && (remain_q == LEN_W'(1))) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        // Leave once the final word has been handed off and nothing returns.
        if ((count_d == 2'd0) && !inflight_d) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_FETCH) || (state_d == ST_DRAIN);
    done_d = (state_d == ST_DONE);
  end

  // All sequencer, FIFO and status state; reset discards any burst in progress.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      remain_q   <= {LEN_W{1'b0}};
      len_q      <= {LEN_W{1'b0}};
      out_idx_q  <= {LEN_W{1'b0}};
      fifo_q     <= {(2 * DATA_W){1'b0}};
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
      inflight_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      remain_q   <= remain_d;
      len_q      <= len_d;
      out_idx_q  <= out_idx_d;
      fifo_q     <= fifo_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      inflight_q <= inflight_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  // The read strobe depends on this cycle's io_outReady, so it cannot be a flop.
  assign io_memRdEn  = rd_en_s;
  assign io_memAddr  = addr_q;
  assign io_outValid = (count_q != 2'd0);
  assign io_outData  = fifo_q[rd_ptr_q];
  assign io_outLast  = io_outValid && (out_idx_q == (len_q - LEN_W'(1)));
  assign io_busy     = busy_q;
  assign io_done     = done_q;

`ifdef DATAPOINT_FETCH_PERF_EN
  logic [15:0] stall_q, stall_d;

  // Stall counter next-state: clear on accepted start, saturate at 16'hFFFF.
  always_comb begin
    if (start_s) begin
      stall_d = 16'd0;
    end else if (io_outValid && !io_outReady && (stall_q != 16'hFFFF) &&
                 ((state_q == ST_FETCH) || (state_q == ST_DRAIN))) begin
      stall_d = stall_q + 16'd1;
    end else begin
      stall_d = stall_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_q <= 16'd0;
    end else begin
      stall_q <= stall_d;
    end
  end

  assign io_stallCycles = stall_q;
`endif

endmodule

// File: tb/tb_datapoint_fetch_streamer.sv
module tb_datapoint_fetch_streamer;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        io_start = 1'b0;
  logic [9:0]  io_baseAddr = 10'd0;
  logic [10:0] io_len = 11'd0;
  logic        io_memRdEn;
  logic [9:0]  io_memAddr;
  logic [15:0] io_memRdData = 16'd0;
  logic        io_outValid;
  logic [15:0] io_outData;
  logic        io_outReady = 1'b1;
  logic        io_outLast;
  logic        io_busy;
  logic        io_done;
`ifdef DATAPOINT_FETCH_PERF_EN
  logic [15:0] io_stallCycles;
`endif

  logic [15:0] mem [1024];
  int n_vec = 0;
  int n_err = 0;

  datapoint_fetch_streamer dut (
    .clock       (clock),
    .reset       (reset),
    .io_start    (io_start),
    .io_baseAddr (io_baseAddr),
    .io_len      (io_len),
    .io_memRdEn  (io_memRdEn),
    .io_memAddr  (io_memAddr),
    .io_memRdData(io_memRdData),
    .io_outValid (io_outValid),
    .io_outData  (io_outData),
    .io_outReady (io_outReady),
    .io_outLast  (io_outLast),
    .io_busy     (io_busy),
    .io_done     (io_done)
`ifdef DATAPOINT_FETCH_PERF_EN
    ,
    .io_stallCycles(io_stallCycles)
`endif
  );

  always #5 clock = ~clock;

  // Memory model: synchronous read with one cycle of latency.
  always @(posedge clock) begin
    if (io_memRdEn) io_memRdData <= mem[io_memAddr];
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_rden"},  32'(io_memRdEn), 32'd0);
    check_eq({tag, "_addr"},  32'(io_memAddr), 32'd0);
    check_eq({tag, "_valid"}, 32'(io_outValid), 32'd0);
    check_eq({tag, "_data"},  32'(io_outData), 32'd0);
    check_eq({tag, "_last"},  32'(io_outLast), 32'd0);
    check_eq({tag, "_busy"},  32'(io_busy), 32'd0);
    check_eq({tag, "_done"},  32'(io_done), 32'd0);
  endtask

  // rmode: 0 = ready always high, 1 = ready pattern 1,0,0 repeating, 2 = random.
  // abort_xfer >= 0 pulls reset low during that (0-based) transfer.
  task automatic run_burst(input logic [9:0] base, input logic [10:0] len, input int rmode,
                           input bit restart, input int abort_xfer);
    int          clen;
    logic [15:0] q[$];
    int          issued = 0;
    int          xfers = 0;
    int          stall = 0;
    bit          done_seen = 1'b0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = 16'd0;
    int          done_cyc;
    clen = (int'(len) > 1024) ? 1024 : int'(len);
    for (int i = 0; i < clen; i++) q.push_back(mem[(int'(base) + i) % 1024]);
    done_cyc = (clen == 0) ? 1 : clen + 3;

    @(negedge clock);
    io_start = 1'b1; io_baseAddr = base; io_len = len; io_outReady = 1'b1;
    for (int cyc = 1; cyc <= 4 * clen + 40 && !done_seen; cyc++) begin
      @(negedge clock);
      io_start    = restart && (cyc == 4);
      io_baseAddr = 10'($urandom);
      io_len      = 11'($urandom_range(1, 2047));
      case (rmode)
        0:       io_outReady = 1'b1;
        1:       io_outReady = ((cyc - 1) % 3 == 0);
        default: io_outReady = 1'($urandom);
      endcase
      #1;
      if (prev_hold) begin
        check_eq("hold_valid", 32'(io_outValid), 32'd1);
        check_eq("hold_data", 32'(io_outData), 32'(prev_data));
      end
      if (io_memRdEn) begin
        check_eq("rd_addr", 32'(io_memAddr), 32'((int'(base) + issued) % 1024));
        issued++;
        check_eq("over_issue", 32'(issued <= clen), 32'd1);
      end
      if (io_outValid && io_outReady) begin
        check_eq("word_avail", 32'(q.size() != 0), 32'd1);
        if (q.size() != 0) begin
          check_eq("out_data", 32'(io_outData), 32'(q[0]));
          check_eq("out_last", 32'(io_outLast), 32'(q.size() == 1));
          void'(q.pop_front());
        end
        if (xfers == abort_xfer) begin
          reset = 1'b0;
          #1;
          check_all_zero("abort");
          for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            check_eq("abort_no_done", 32'(io_done), 32'd0);
          end
          reset = 1'b1;
          io_start = 1'b0;
          return;
        end
        xfers++;
      end
      if (io_outValid && !io_outReady) stall++;
      check_eq("occupancy", 32'((issued - xfers) <= 2), 32'd1);
      if (rmode == 0) begin
        check_eq("done_timing", 32'(io_done), 32'(cyc == done_cyc));
        check_eq("busy", 32'(io_busy), 32'((clen != 0) && (cyc < done_cyc)));
      end else if (!io_done) begin
        check_eq("busy", 32'(io_busy), 32'(clen != 0));
      end
      if (io_done) begin
        done_seen = 1'b1;
        check_eq("done_count", 32'(xfers), 32'(clen));
        check_eq("done_valid", 32'(io_outValid), 32'd0);
`ifdef DATAPOINT_FETCH_PERF_EN
        check_eq("stall_cycles", 32'(io_stallCycles), 32'(stall));
`endif
      end
      prev_hold = io_outValid && !io_outReady;
      prev_data = io_outData;
    end
    io_start = 1'b0;
    if (!done_seen) check_eq("timeout", 32'(done_seen), 32'd1);
    @(negedge clock);
    #1;
    check_eq("done_pulse", 32'(io_done), 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'(i + 16'h0100);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    #1;
    check_all_zero("reset");
    reset = 1'b1;

    run_burst(10'd4,    11'd3,    0, 1'b0, -1);
    run_burst(10'd1022, 11'd4,    0, 1'b0, -1);
    run_burst(10'd0,    11'd0,    0, 1'b0, -1);
    run_burst(10'($urandom), 11'd8, 1, 1'b0, -1);
    run_burst(10'd7,    11'd10,   0, 1'b0, 4);
    run_burst(10'd0,    11'd2,    0, 1'b0, -1);
    run_burst(10'd100,  11'd8,    0, 1'b1, -1);
    run_burst(10'd1000, 11'd1500, 0, 1'b0, -1);
    for (int t = 0; t < 12; t++) begin
      run_burst(10'($urandom), 11'($urandom_range(0, 40)), 2, 1'($urandom), -1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
